// File: rtl/clock_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM state type and
// the smallest divide ratio that still yields a high and a low phase.
package clock_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clock_div_counter.sv
// Period counter for the clock divider: counts 0..ratio-1, flags the wrap and
// registers the duty-cycle compare and the period-start tick.
module clock_div_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             run_next,
  input  logic [DIV_W-1:0] ratio,
  input  logic [DIV_W-1:0] ratio_next,
  output logic [DIV_W-1:0] cnt,
  output logic             wrap,
  output logic             out_clk,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_next;
  logic             out_next;
  logic             tick_next;

  // High phase length ceil(n/2), computed without widening.
  function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] n);
    return n - (n >> 1);
  endfunction

  assign wrap = active && (cnt == ratio - DIV_W'(1));

  always_comb begin
    cnt_next  = '0;
    out_next  = 1'b0;
    tick_next = 1'b0;
    if (run_next) begin
      cnt_next  = (active && !wrap) ? cnt + DIV_W'(1) : '0;
      out_next  = (cnt_next < high_len(ratio_next));
      tick_next = (cnt_next == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      out_clk <= out_next;
      tick    <= tick_next;
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// Programmable integer clock divider: IDLE/RUN control, shadow and active
// ratio registers, with ratio changes applied only at period boundaries.
module programmable_clock_divider
  import clock_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             out_clk,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] cur_div
);

  state_t           state, state_next;
  logic [DIV_W-1:0] n_sh, n_act;
  logic [DIV_W-1:0] sh_next, act_next;
  logic [DIV_W-1:0] cnt;
  logic             wrap;
  logic             update;

  function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
    return (r < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : r;
  endfunction

  // A load coinciding with start or boundary takes effect immediately.
  assign sh_next  = load ? clamp_ratio(div_ratio) : n_sh;
  assign update   = (state == IDLE && en) || (wrap && en);
  assign act_next = update ? sh_next : n_act;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (wrap && !en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      n_sh  <= DIV_W'(DEFAULT_DIV);
      n_act <= DIV_W'(DEFAULT_DIV);
    end else begin
      state <= state_next;
      n_sh  <= sh_next;
      n_act <= act_next;
    end
  end

  clock_div_counter #(
    .DIV_W(DIV_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .active    (state == RUN),
    .run_next  (state_next == RUN),
    .ratio     (n_act),
    .ratio_next(act_next),
    .cnt       (cnt),
    .wrap      (wrap),
    .out_clk   (out_clk),
    .tick      (tick)
  );

  assign running = (state == RUN);
  assign cur_div = n_act;

endmodule

// File: doc/programmable_clock_divider.md
PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the divide ratio.
REQ-002 SHALL have parameter DEFAULT_DIV, default 2, divide ratio loaded at reset (legal range 2..2^DIV_W-1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing div_ratio into the shadow register.
REQ-007 SHALL have port div_ratio  input  DIV_W  requested divide ratio N.
REQ-008 SHALL have port out_clk  output  1  divided clock, registered, glitch-free.
REQ-009 SHALL have port tick  output  1  one-clk pulse marking each out_clk rising edge.
REQ-010 SHALL have port running  output  1  high while state is RUN.
REQ-011 SHALL have port cur_div  output  DIV_W  ratio currently in effect (N_act).

Function
REQ-012 SHALL implement a two-state FSM: IDLE, RUN.
REQ-013 SHALL hold a shadow ratio N_sh and an active ratio N_act, plus a DIV_W-bit counter cnt.
REQ-014 SHALL, on load high, capture N_sh = max(div_ratio, 2); values 0 and 1 clamp to 2.
REQ-015 SHALL, in IDLE, hold cnt=0, out_clk=0, tick=0, running=0.
REQ-016 SHALL, in IDLE with en=1 sampled, enter RUN on the next edge with cnt=0, out_clk=1, tick=1, N_act=N_sh.
REQ-017 SHALL, in RUN, increment cnt every cycle and wrap from N_act-1 to 0; this wrap cycle is the period boundary.
REQ-018 SHALL drive out_clk=1 for cnt in [0, H-1] and 0 for cnt in [H, N_act-1], H = ceil(N_act/2): exact 50% duty for even N; for odd N, high (N+1)/2 and low (N-1)/2 cycles.
REQ-019 SHALL assert tick exactly in cycles where running=1 and cnt=0.
REQ-020 SHALL copy N_sh into N_act only at the period boundary; the ratio never changes mid-period.
REQ-021 SHALL, when load and the boundary coincide, apply the newly loaded value at that same boundary.
REQ-022 SHALL, when en=0 at the boundary, go to IDLE on that edge (out_clk=0, no tick); en deasserted mid-period lets the current period complete.
REQ-023 SHALL keep running if en returns to 1 before the boundary, with no disturbance to out_clk.
REQ-024 SHALL never produce an out_clk high or low phase shorter than 1 clk cycle or a partial period.
REQ-025 SHALL drive cur_div = N_act at all times.

Reset
REQ-026 SHALL, on rst=0, asynchronously force state=IDLE, cnt=0, out_clk=0, tick=0, running=0, N_sh=N_act=DEFAULT_DIV.
REQ-027 SHALL, when reset is asserted mid-period, abandon the period immediately; after release it restarts only through REQ-016.

Structure
REQ-028 SHALL take the FSM state enum and constant MIN_DIV=2 from shared package clock_div_pkg.
REQ-029 SHALL place counter, wrap detect and duty compare in one sub-module, clock_div_counter; FSM and ratio registers remain at top level.

Verification
REQ-030 SHALL verify reset default: rst low, then release, en=1 -> out_clk period 2 clk cycles, 1 high/1 low, cur_div=2.
REQ-031 SHALL verify odd ratio: load div_ratio=5, en=1 -> out_clk 3 high/2 low, tick every 5 cycles.
REQ-032 SHALL verify boundary-only update: running N=4, load 6 at cnt=1 -> current period stays 4 cycles, next period 6 cycles (3/3), cur_div changes at the wrap.
REQ-033 SHALL verify clamping: load div_ratio=0, then 1 -> cur_div=2 after the next boundary.
REQ-034 SHALL verify stop: N=8, en dropped at cnt=2 -> 8-cycle period completes, then running=0, out_clk=0, no further tick; en pulsed low at cnt=3 and high at cnt=5 -> no disturbance.
REQ-035 SHALL verify async reset mid-run: rst=0 at cnt=3 of N=7 -> outputs zero without a clock edge, cur_div=DEFAULT_DIV.
